// File: rtl/mmio_io_ctrl_pkg.sv
// Shared definitions for the MMIO GPIO/interrupt controller:
// register offsets within the 8-byte window and the request FSM state type.
package mmio_io_pkg;

    localparam logic [2:0] OFS_GPIO_OUT = 3'd0;
    localparam logic [2:0] OFS_GPIO_DIR = 3'd1;
    localparam logic [2:0] OFS_GPIO_IN  = 3'd2;
    localparam logic [2:0] OFS_IRQ_PEND = 3'd3;
    localparam logic [2:0] OFS_IRQ_MASK = 3'd4;
    localparam logic [2:0] OFS_VEC_BASE = 3'd5;
    localparam logic [2:0] OFS_IRQ_CUR  = 3'd6;
    localparam logic [2:0] OFS_EOI      = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// CPU data-port and interrupt handshake bundle between the core (master)
// and the MMIO controller (slave).
interface mmio_io_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              w_en;
    logic [DATA_W-1:0] rdata;
    logic              hit;
    logic              int_req;
    logic              int_ack;
    logic [DATA_W-1:0] int_vec;

    modport master (
        output addr, wdata, w_en, int_ack,
        input  rdata, hit, int_req, int_vec
    );

    modport slave (
        input  addr, wdata, w_en, int_ack,
        output rdata, hit, int_req, int_vec
    );
endinterface

// File: rtl/mmio_io_ctrl_sync_edge.sv
// Multi-stage synchroniser for asynchronous inputs with an async clear,
// plus a rising-edge detect on the synchronised value.
module sync_edge #(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_rise
);
    logic [W-1:0] r_stage [STAGES];
    logic [W-1:0] r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) r_stage[i] <= '0;
            r_prev <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
            r_prev <= r_stage[STAGES-1];
        end
    end

    assign o_sync = r_stage[STAGES-1];
    assign o_rise = o_sync & ~r_prev;
endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped GPIO bank and fixed-priority maskable interrupt controller
// on the CPU data port, with an int_req/int_ack/EOI handshake.
module mmio_io_ctrl
    import mmio_io_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DATA_W      = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'hF0,
    parameter int unsigned       N_GPIO      = 8,
    parameter int unsigned       N_IRQ       = 4,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       VEC_STRIDE  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    mmio_io_ctrl_if.slave     bus,
    input  logic [N_IRQ-1:0]  irq_src,
    input  logic [N_GPIO-1:0] gpio_in_pad,
    output logic [N_GPIO-1:0] gpio_out_pad,
    output logic [N_GPIO-1:0] gpio_oeb
);
    localparam int unsigned NSRC  = N_IRQ + 1;
    localparam int unsigned IDX_W = $clog2(N_IRQ + 1);

    logic [N_GPIO-1:0] r_gpio_out;
    logic [N_GPIO-1:0] r_gpio_dir;
    logic [N_GPIO-1:0] r_gpio_prev;
    logic [NSRC-1:0]   r_pend;
    logic [NSRC-1:0]   r_mask;
    logic [DATA_W-1:0] r_vec_base;
    logic [DATA_W-1:0] r_vec;
    logic [IDX_W-1:0]  r_idx;
    irq_state_t        r_state;

    logic [N_GPIO-1:0] w_gpio_sync;
    logic [N_GPIO-1:0] w_gpio_rise_unused;
    logic [N_GPIO-1:0] w_gpio_chg;
    logic [N_IRQ-1:0]  w_irq_sync_unused;
    logic [N_IRQ-1:0]  w_irq_rise;
    logic              w_hit;
    logic [2:0]        w_ofs;
    logic              w_we;
    logic              w_eoi;
    logic [NSRC-1:0]   w_set;
    logic [NSRC-1:0]   w_w1c;
    logic [NSRC-1:0]   w_ack_clr;
    logic [NSRC-1:0]   w_active;
    logic [IDX_W-1:0]  w_win;
    logic              w_cur_live;
    logic              w_latch;
    logic              w_int_req;
    irq_state_t        w_state_nxt;
    logic [DATA_W-1:0] w_cur;
    logic [DATA_W-1:0] w_rdata;

    sync_edge #(.W(N_GPIO), .STAGES(SYNC_STAGES)) u_sync_gpio (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_d     (gpio_in_pad),
        .o_sync  (w_gpio_sync),
        .o_rise  (w_gpio_rise_unused)
    );

    sync_edge #(.W(N_IRQ), .STAGES(SYNC_STAGES)) u_sync_irq (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_d     (irq_src),
        .o_sync  (w_irq_sync_unused),
        .o_rise  (w_irq_rise)
    );

    assign w_hit = (bus.addr[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
    assign w_ofs = bus.addr[2:0];
    assign w_we  = bus.w_en & w_hit;
    assign w_eoi = w_we && (w_ofs == OFS_EOI);

    // Only pins configured as inputs contribute to the change interrupt.
    assign w_gpio_chg = (w_gpio_sync ^ r_gpio_prev) & ~r_gpio_dir;
    assign w_set      = {|w_gpio_chg, w_irq_rise};
    assign w_w1c      = (w_we && (w_ofs == OFS_IRQ_PEND)) ? bus.wdata[NSRC-1:0] : '0;
    assign w_active   = r_pend & r_mask;
    assign w_cur_live = r_pend[r_idx] & r_mask[r_idx];

    always_comb begin
        logic w_found;
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (w_active[i] && !w_found) begin
                w_found = 1'b1;
                w_win   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gpio_out  <= '0;
            r_gpio_dir  <= '0;
            r_gpio_prev <= '0;
            r_mask      <= '0;
            r_vec_base  <= '0;
            r_pend      <= '0;
        end else begin
            r_gpio_prev <= w_gpio_sync;
            // A new edge outranks a W1C or ack clear in the same cycle.
            r_pend      <= (r_pend & ~(w_w1c | w_ack_clr)) | w_set;
            if (w_we) begin
                case (w_ofs)
                    OFS_GPIO_OUT: r_gpio_out <= bus.wdata[N_GPIO-1:0];
                    OFS_GPIO_DIR: r_gpio_dir <= bus.wdata[N_GPIO-1:0];
                    OFS_IRQ_MASK: r_mask     <= bus.wdata[NSRC-1:0];
                    OFS_VEC_BASE: r_vec_base <= bus.wdata;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // The request is withdrawn combinationally as soon as its source is no
    // longer pending-and-enabled, so the CPU never acks a stale vector.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_int_req   = 1'b0;
        w_ack_clr   = '0;
        case (r_state)
            IDLE: begin
                if (|w_active) begin
                    w_latch     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (!w_cur_live) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_int_req = 1'b1;
                    if (bus.int_ack) begin
                        w_ack_clr[r_idx] = 1'b1;
                        w_state_nxt      = SERVICE;
                    end
                end
            end
            SERVICE: begin
                if (w_eoi) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
            r_vec <= '0;
        end else if (w_latch) begin
            r_idx <= w_win;
            r_vec <= r_vec_base + DATA_W'(w_win) * DATA_W'(VEC_STRIDE);
        end
    end

    always_comb begin
        w_cur             = '0;
        w_cur[DATA_W-1]   = (r_state == SERVICE);
        w_cur[IDX_W-1:0]  = r_idx;
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_ofs)
                OFS_GPIO_OUT: w_rdata[N_GPIO-1:0] = r_gpio_out;
                OFS_GPIO_DIR: w_rdata[N_GPIO-1:0] = r_gpio_dir;
                OFS_GPIO_IN:  w_rdata[N_GPIO-1:0] = w_gpio_sync;
                OFS_IRQ_PEND: w_rdata[NSRC-1:0]   = r_pend;
                OFS_IRQ_MASK: w_rdata[NSRC-1:0]   = r_mask;
                OFS_VEC_BASE: w_rdata             = r_vec_base;
                OFS_IRQ_CUR:  w_rdata             = w_cur;
                default: ;
            endcase
        end
    end

    assign bus.rdata    = w_rdata;
    assign bus.hit      = w_hit;
    assign bus.int_req  = w_int_req;
    assign bus.int_vec  = r_vec;
    assign gpio_out_pad = r_gpio_out;
    assign gpio_oeb     = ~r_gpio_dir;
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl: GPIO, priority, withdraw, W1C collision,
// mask/vector wrap, stray handshakes and asynchronous reset.
module tb_mmio_io_ctrl;
    logic       clock;
    logic       reset_n;
    logic [3:0] irq_src;
    logic [7:0] gpio_in_pad;
    logic [7:0] gpio_out_pad;
    logic [7:0] gpio_oeb;
    int         n_chk;
    int         n_err;

    mmio_io_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mmio_io_ctrl #(
        .ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'hF0), .N_GPIO(8),
        .N_IRQ(4), .SYNC_STAGES(2), .VEC_STRIDE(4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .irq_src      (irq_src),
        .gpio_in_pad  (gpio_in_pad),
        .gpio_out_pad (gpio_out_pad),
        .gpio_oeb     (gpio_oeb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.w_en  = 1'b1;
        tick(1);
        bus.w_en  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] ofs, input logic [7:0] exp);
        logic [7:0] a;
        a        = 8'hF0 | {5'd0, ofs};
        bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    task automatic ack_pulse();
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset_n = 1'b0;
        bus.addr = '0; bus.wdata = '0; bus.w_en = 1'b0; bus.int_ack = 1'b0;
        irq_src = '0; gpio_in_pad = '0;
        #23 reset_n = 1'b1;
        tick(1);

        chk("rst_int_req", bus.int_req, 1'b0);
        chk("rst_oeb", gpio_oeb, 8'hFF);
        chk("rst_vec", bus.int_vec, 8'h00);
        for (int i = 0; i < 8; i++) rd("rst_reg", 3'(i), 8'h00);
        tick(1);
        bus.addr = 8'hEF; #1;
        chk("hit_below", bus.hit, 1'b0);
        bus.addr = 8'hF7; #1;
        chk("hit_top", bus.hit, 1'b1);

        // GPIO
        wr(8'hF1, 8'h0F);
        wr(8'hF0, 8'hA5);
        chk("gpio_out", gpio_out_pad, 8'hA5);
        chk("gpio_oeb", gpio_oeb, 8'hF0);
        wr(8'hE8, 8'h11);
        chk("out_of_window_wr", gpio_out_pad, 8'hA5);
        bus.addr = 8'hE8; #1;
        chk("rd_miss_zero", bus.rdata, 8'h00);
        gpio_in_pad = 8'h30;
        tick(3);
        rd("gpio_in", 3'd2, 8'h30);
        rd("pend_gpio", 3'd3, 8'h10);
        chk("no_req_masked", bus.int_req, 1'b0);
        wr(8'hF3, 8'h10);
        gpio_in_pad = 8'h31;
        tick(4);
        rd("gpio_in_out_pin", 3'd2, 8'h31);
        rd("pend_out_pin", 3'd3, 8'h00);

        // Priority
        wr(8'hF4, 8'h1F);
        wr(8'hF5, 8'h40);
        irq_src = 4'b0110;
        tick(4);
        chk("prio_req", bus.int_req, 1'b1);
        chk("prio_vec", bus.int_vec, 8'h44);
        rd("prio_pend", 3'd3, 8'h06);
        rd("prio_cur", 3'd6, 8'h01);
        ack_pulse();
        chk("ack_req_drop", bus.int_req, 1'b0);
        rd("ack_pend", 3'd3, 8'h04);
        rd("ack_cur", 3'd6, 8'h81);
        wr(8'hF7, 8'h5A);
        chk("eoi_gap", bus.int_req, 1'b0);
        tick(1);
        chk("second_req", bus.int_req, 1'b1);
        chk("second_vec", bus.int_vec, 8'h48);
        ack_pulse();
        rd("second_pend", 3'd3, 8'h00);
        wr(8'hF7, 8'h00);
        tick(3);
        rd("level_no_reset", 3'd3, 8'h00);
        chk("level_no_req", bus.int_req, 1'b0);

        // Withdraw
        irq_src = 4'b1000;
        tick(4);
        chk("wd_req", bus.int_req, 1'b1);
        chk("wd_vec", bus.int_vec, 8'h4C);
        wr(8'hF3, 8'h08);
        chk("wd_drop", bus.int_req, 1'b0);
        tick(1);
        rd("wd_cur", 3'd6, 8'h03);
        chk("wd_idle_req", bus.int_req, 1'b0);

        // Mask = 0, then W1C/edge collision
        irq_src = 4'b0000;
        wr(8'hF4, 8'h00);
        irq_src = 4'b0001;
        tick(4);
        rd("mask0_pend", 3'd3, 8'h01);
        chk("mask0_no_req", bus.int_req, 1'b0);
        irq_src = 4'b0000;
        tick(3);
        irq_src = 4'b0001;
        tick(2);
        wr(8'hF3, 8'h01);
        rd("collision_set_wins", 3'd3, 8'h01);
        wr(8'hF3, 8'h01);
        tick(2);
        rd("w1c_level_held", 3'd3, 8'h00);

        // Stray handshakes in IDLE
        ack_pulse();
        rd("stray_ack_cur", 3'd6, 8'h03);
        rd("stray_ack_pend", 3'd3, 8'h00);
        wr(8'hF7, 8'h00);
        rd("stray_eoi_cur", 3'd6, 8'h03);

        // Vector wrap, EOI during REQ ignored
        wr(8'hF5, 8'hFE);
        wr(8'hF4, 8'h02);
        irq_src = 4'b0011;
        tick(4);
        chk("wrap_req", bus.int_req, 1'b1);
        chk("wrap_vec", bus.int_vec, 8'h02);
        wr(8'hF7, 8'h00);
        chk("eoi_in_req_ignored", bus.int_req, 1'b1);
        rd("eoi_in_req_cur", 3'd6, 8'h01);
        ack_pulse();
        rd("wrap_svc_cur", 3'd6, 8'h81);

        // Async reset during REQ
        wr(8'hF7, 8'h00);
        irq_src = 4'b0000;
        tick(3);
        irq_src = 4'b0010;
        tick(4);
        chk("pre_rst_req", bus.int_req, 1'b1);
        reset_n = 1'b0;
        #2;
        chk("async_rst_req", bus.int_req, 1'b0);
        chk("async_rst_oeb", gpio_oeb, 8'hFF);
        chk("async_rst_out", gpio_out_pad, 8'h00);
        chk("async_rst_vec", bus.int_vec, 8'h00);
        irq_src = 4'b0000;
        gpio_in_pad = 8'h00;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        for (int i = 0; i < 8; i++) rd("post_rst_reg", 3'(i), 8'h00);
        tick(2);
        chk("post_rst_idle", bus.int_req, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
